harp_uart_tx: RTL

//  8N1 UART transmitter directly downstream of the Harp timestamp sequencer.

---
 rtl/harp_pkg.sv | 22 ++
 rtl/harp_baud_tick.sv | 34 +++
 rtl/harp_uart_tx.sv | 97 +++++++++
 3 files changed

// File: rtl/harp_pkg.sv
// Shared Harp definitions: UART FSM encoding, frame constants and sync bytes.
package harp_pkg;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  localparam int DATA_BITS  = 8;
  localparam int FRAME_BITS = 10;

  localparam logic [7:0] SYNC_0 = 8'hAA;
  localparam logic [7:0] SYNC_1 = 8'hAF;

  localparam int DEFAULT_BAUD = 100000;

  // Integer division floors non-integer clock/baud ratios.
  function automatic int clocks_per_bit(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/harp_baud_tick.sv
// Bit-period divider: counts 0..CPB-1 and raises tick in the last cycle of each bit.
module harp_baud_tick #(
  parameter int CPB = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int CW = (CPB > 1) ? $clog2(CPB) : 1;
  localparam logic [CW-1:0] LAST = CW'(CPB - 1);

  generate
    if (CPB < 2) begin : g_cpb_check
      $error("harp_baud_tick: CPB must be at least 2");
    end
  endgenerate

  logic [CW-1:0] baud_cnt;

  always_ff @(posedge clk) begin
    if (!reset || clear) begin
      baud_cnt <= '0;
    end else if (baud_cnt == LAST) begin
      baud_cnt <= '0;
    end else begin
      baud_cnt <= baud_cnt + 1'b1;
    end
  end

  assign tick = (baud_cnt == LAST);

endmodule

// File: rtl/harp_uart_tx.sv
// 8N1 UART transmitter for the Harp timestamp stream; blank frames keep slot timing but stay idle-high.
module harp_uart_tx
  import harp_pkg::*;
#(
  parameter int CLK_HZ = 1000000,
  parameter int BAUD   = DEFAULT_BAUD
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] uart_data,
  input  logic       uart_start,
  input  logic       uart_blank,
  output logic       tx,
  output logic       uart_end,
  output logic       busy,
  output logic [1:0] state_dbg
);

  localparam int CPB = clocks_per_bit(CLK_HZ, BAUD);

  generate
    if (CPB < 2) begin : g_cpb_check
      $error("harp_uart_tx: CLK_HZ/BAUD must be at least 2");
    end
  endgenerate

  // Handshake: uart_start is a request pulse accepted only in S_IDLE; there is no
  // ready/queue, so a start while busy (including the uart_end cycle) is dropped.
  logic [1:0] state;
  logic [7:0] shift_reg;
  logic       blank_q;
  logic [2:0] bit_cnt;
  logic       tick;
  logic       start_accept;

  assign start_accept = (state == S_IDLE) && uart_start;

  harp_baud_tick #(.CPB(CPB)) u_baud_tick (
    .clk   (clk),
    .reset (reset),
    .clear (start_accept),
    .tick  (tick)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= S_IDLE;
      tx        <= 1'b1;
      shift_reg <= '0;
      blank_q   <= 1'b0;
      bit_cnt   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          tx <= 1'b1;
          if (uart_start) begin
            shift_reg <= uart_data;
            blank_q   <= uart_blank;
            bit_cnt   <= '0;
            tx        <= uart_blank;
            state     <= S_START;
          end
        end
        S_START: begin
          if (tick) begin
            tx    <= blank_q | shift_reg[0];
            state <= S_DATA;
          end
        end
        S_DATA: begin
          if (tick) begin
            shift_reg <= {1'b0, shift_reg[7:1]};
            bit_cnt   <= bit_cnt + 1'b1;
            // After the last data bit the line goes to the stop level.
            if (bit_cnt == 3'(DATA_BITS - 1)) begin
              tx    <= 1'b1;
              state <= S_STOP;
            end else begin
              tx <= blank_q | shift_reg[1];
            end
          end
        end
        default: begin
          tx <= 1'b1;
          if (tick) begin
            state <= S_IDLE;
          end
        end
      endcase
    end
  end

  assign uart_end  = (state == S_STOP) && tick;
  assign busy      = (state != S_IDLE);
  assign state_dbg = state;

endmodule
